// File: rtl/div_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_pkg : shared constants and FSM state type for the div32_iter divider
// Revision: 1.0
// ----------------------------------------------------------------------------
package div_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int CNT_W      = 6;
  localparam int ITER_COUNT = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_negate32.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div_negate32 : 32-bit two's-complement negation (invert and add one)
// Revision: 1.0
// ----------------------------------------------------------------------------
module div_negate32 (
  input  logic [31:0] value,
  output logic [31:0] negated
);

  assign negated = ~value + 32'd1;

endmodule
`default_nettype wire

// File: rtl/div32_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// div32_iter : iterative 32-bit restoring divider, one quotient bit per clock.
// Build option: DIV_SIGNED_EN selects two's-complement operands.
// Revision: 1.0
// ----------------------------------------------------------------------------
module div32_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           state;
  state_t           state_nx;
  logic             start_ok;
  logic             div_zero;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;
  logic             exc_fix;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nx;
  logic             unused_trial_msb;

  // Restoring step: shift in the next dividend bit, keep the subtract if it fits.
  assign shifted          = {rem, quo[WIDTH-1]};
  assign fits             = (shifted >= {1'b0, dvs});
  assign trial            = shifted - {1'b0, dvs};
  assign rem_nx           = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign unused_trial_msb = trial[WIDTH];

`ifdef DIV_SIGNED_EN
  logic [WIDTH-1:0] neg_a;
  logic [WIDTH-1:0] neg_b;
  logic [WIDTH-1:0] neg_quo;
  logic [WIDTH-1:0] neg_rem;
  logic             neg_q_sel;
  logic             neg_r_sel;
  logic             ovf;

  div_negate32 u_neg_a   (.value(data_operandA), .negated(neg_a));
  div_negate32 u_neg_b   (.value(data_operandB), .negated(neg_b));
  div_negate32 u_neg_quo (.value(quo),           .negated(neg_quo));
  div_negate32 u_neg_rem (.value(rem),           .negated(neg_rem));

  assign mag_a   = data_operandA[WIDTH-1] ? neg_a : data_operandA;
  assign mag_b   = data_operandB[WIDTH-1] ? neg_b : data_operandB;
  assign fix_q   = neg_q_sel ? neg_quo : quo;
  assign fix_r   = neg_r_sel ? neg_rem : rem;
  assign exc_fix = ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      neg_q_sel <= 1'b0;
      neg_r_sel <= 1'b0;
      ovf       <= 1'b0;
    end else if (start_ok) begin
      neg_q_sel <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      neg_r_sel <= data_operandA[WIDTH-1];
      ovf       <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                   (data_operandB == {WIDTH{1'b1}});
    end
  end
`else
  assign mag_a   = data_operandA;
  assign mag_b   = data_operandB;
  assign fix_q   = quo;
  assign fix_r   = rem;
  assign exc_fix = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    start_ok       = 1'b0;
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_div) begin
          start_ok = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (div_zero) begin
          state_nx = ST_DONE;
        end else if (cnt == CNT_W'(ITER_COUNT - 1)) begin
          state_nx = ST_FIX;
        end
      end
      ST_FIX: begin
        busy     = 1'b1;
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        data_resultRDY = 1'b1;
        if (ctrl_div) begin
          start_ok = 1'b1;
          state_nx = ST_RUN;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A zero divisor keeps the raw dividend in quo so it can be returned as the remainder.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      quo            <= '0;
      dvs            <= '0;
      rem            <= '0;
      div_zero       <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (start_ok) begin
      cnt            <= '0;
      rem            <= '0;
      div_zero       <= (data_operandB == '0);
      quo            <= (data_operandB == '0) ? data_operandA : mag_a;
      dvs            <= mag_b;
      data_exception <= 1'b0;
    end else if (state == ST_RUN) begin
      if (div_zero) begin
        data_result    <= '0;
        data_remainder <= quo;
        data_exception <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
        rem <= rem_nx;
        quo <= {quo[WIDTH-2:0], fits};
      end
    end else if (state == ST_FIX) begin
      data_result    <= fix_q;
      data_remainder <= fix_r;
      data_exception <= exc_fix;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div32_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_div32_iter : self-checking bench for div32_iter against an arithmetic model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_div32_iter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  div32_iter dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_div       (ctrl_div),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic e);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'd0; r = a; e = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = 32'd0; e = 1'b1;
      end else begin
        q = sa / sb; r = sa % sb; e = 1'b0;
      end
`else
      q = a / b; r = a % b; e = 1'b0;
`endif
    end
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    ctrl_div      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_div = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // n0 = negedges already elapsed since the accepting edge.
  task automatic wait_done(input logic [31:0] a, input logic [31:0] b,
                           input int n0, input string tag);
    logic [31:0] eq, er;
    logic        ee;
    int          n;
    n = n0;
    model(a, b, eq, er, ee);
    while (!data_resultRDY && n < 80) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_latency"}, 32'(n), (b == 32'd0) ? 32'd1 : 32'd33);
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, data_result, eq);
    check({tag, "_remainder"}, data_remainder, er);
    check({tag, "_exception"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] eq, er;
    logic        ee;
    model(a, b, eq, er, ee);
    do_start(a, b);
    wait_done(a, b, 0, tag);
    @(negedge clock);
    check({tag, "_pulse_single"}, {31'd0, data_resultRDY}, 32'd0);
    repeat ($urandom_range(0, 3)) @(negedge clock);
    check({tag, "_hold_result"}, data_result, eq);
    check({tag, "_hold_exception"}, {31'd0, data_exception}, {31'd0, ee});
  endtask

  initial begin
    int pulses;
    logic [31:0] a, b;

    repeat (3) @(negedge clock);
    check("reset_result", data_result, 32'd0);
    check("reset_remainder", data_remainder, 32'd0);
    check("reset_exception", {31'd0, data_exception}, 32'd0);
    check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    // First start on the very first edge out of reset.
    reset_n = 1'b1;
    run_one(32'd100, 32'd7, "div_100_7");
    run_one(32'd5, 32'd0, "div_5_0");
    run_one(32'd12345, 32'd12345, "div_equal");
    run_one(32'd3, 32'd10, "div_small");
    run_one(32'hFFFF_FFFF, 32'd1, "div_by_one");
`ifdef DIV_SIGNED_EN
    run_one(32'hFFFF_FF9C, 32'd7, "sdiv_m100_7");
    run_one(32'h8000_0000, 32'hFFFF_FFFF, "sdiv_ovf");
    run_one(32'd100, 32'hFFFF_FFF9, "sdiv_100_m7");
    run_one(32'hFFFF_FFF0, 32'd0, "sdiv_neg_by_0");
`endif

    // A start request while running is ignored.
    do_start(32'd50, 32'd5);
    repeat (4) @(negedge clock);
    ctrl_div = 1'b1; data_operandA = 32'd80; data_operandB = 32'd4;
    @(negedge clock);
    ctrl_div = 1'b0;
    wait_done(32'd50, 32'd5, 5, "ignored_start");

    // Back-to-back: new start accepted during the DONE cycle.
    do_start(32'd81, 32'd9);
    wait_done(32'd81, 32'd9, 0, "b2b_first");
    do_start(32'd1000, 32'd33);
    wait_done(32'd1000, 32'd33, 0, "b2b_second");
    @(negedge clock);

    // Reset in the middle of a division.
    do_start(32'd1000, 32'd10);
    repeat (9) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", data_result, 32'd0);
    check("abort_remainder", data_remainder, 32'd0);
    check("abort_exception", {31'd0, data_exception}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    check("abort_no_pulse", 32'(pulses), 32'd0);
    run_one(32'd9, 32'd3, "after_abort");

    // Randomized operands.
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 1000);
        4:       b = a;
        default: b = $urandom;
      endcase
`ifdef DIV_SIGNED_EN
      if ($urandom_range(0, 14) == 0) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
`endif
      run_one(a, b, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/div32_iter.md
DIV32_ITER -- requirements
Module: div32_iter

Interface
REQ-001 Parameter WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 Port clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port ctrl_div  in  1  start request, sampled on the rising edge.
REQ-005 Port data_operandA  in  32  dividend, sampled with an accepted start.
REQ-006 Port data_operandB  in  32  divisor, sampled with an accepted start.
REQ-007 Port data_result  out  32  quotient.
REQ-008 Port data_remainder  out  32  remainder.
REQ-009 Port data_exception  out  1  divide-by-zero or overflow flag.
REQ-010 Port data_resultRDY  out  1  single-cycle completion pulse.
REQ-011 Port busy  out  1  high while a division is in flight.

Function
REQ-012 States: IDLE, RUN, FIX, DONE; FSM is the only sequencing element.
REQ-013 Start is accepted when ctrl_div=1 in IDLE or DONE; ctrl_div in RUN or FIX is ignored.
REQ-014 Accepted start at edge k: operands latched, 6-bit counter cleared, busy=1 from edge k; go to RUN.
REQ-015 RUN: restoring division, one quotient bit per edge, MSB first, 33-bit partial-remainder subtract; 32 edges (k+1..k+32), then FIX.
REQ-016 FIX (edge k+33): sign correction applied, data_result/data_remainder loaded, go to DONE.
REQ-017 data_resultRDY=1 and busy=0 for exactly the cycle after edge k+33; total latency 34 edges from start.
REQ-018 DONE lasts one cycle, then IDLE unless a new start is accepted there.
REQ-019 Divisor 0 at start: skip RUN/FIX; at edge k+1 data_result=0, data_remainder=dividend, data_exception=1, pulse data_resultRDY.
REQ-020 data_exception is cleared by the next accepted start; 0 for every normal completion.
REQ-021 data_result, data_remainder, data_exception hold their values until the next accepted start.
REQ-022 Remainder sign equals dividend sign; |remainder| < |divisor|.

Reset
REQ-023 reset_n=0 forces IDLE immediately and zeroes all outputs, counter and latched operands.
REQ-024 Reset mid-operation aborts the division; no data_resultRDY pulse is produced for it.
REQ-025 First start is accepted on the first rising edge with reset_n=1.

Configuration
REQ-026 Macro DIV_SIGNED_EN defined: two's-complement operands; magnitudes divided, quotient negated when signs differ, remainder negated when dividend negative.
REQ-027 DIV_SIGNED_EN defined: 0x80000000 / 0xFFFFFFFF gives data_result=0x80000000, data_remainder=0, data_exception=1, normal 34-edge latency.
REQ-028 DIV_SIGNED_EN undefined: operands unsigned, FIX is a pass-through cycle (latency unchanged), no overflow case exists.

Structure
REQ-029 Package div_pkg holds WIDTH constant, counter width, FSM state enum, and iteration count (32).
REQ-030 One sub-module, div_negate32: 32-bit two's-complement negation (bitwise inversion plus one), instantiated for operand magnitudes and result fixup.

Verification
REQ-031 100 / 7 -> at edge k+34 window: data_result=14, data_remainder=2, data_exception=0, data_resultRDY one cycle.
REQ-032 DIV_SIGNED_EN: -100 / 7 -> data_result=0xFFFFFFF2, data_remainder=0xFFFFFFFE, data_exception=0.
REQ-033 5 / 0 -> after edge k+1: data_result=0, data_remainder=5, data_exception=1, data_resultRDY one cycle.
REQ-034 DIV_SIGNED_EN: 0x80000000 / 0xFFFFFFFF -> data_result=0x80000000, data_exception=1 at 34-edge latency.
REQ-035 Start 1000/10, reset_n=0 at edge k+10 -> busy=0, outputs 0, no pulse; new start 9/3 -> data_result=3.
REQ-036 Start 50/5, second ctrl_div 80/4 at edge k+5 -> ignored, data_result=10; start in DONE cycle accepted back-to-back.
